ictc_irq_ctrl_regs: RTL and testbench

Parametrised interrupt enable/status/pending register bank for the ictc interrupt controller. It generalises the single-bit interrupt enable register to NUM_CH channels. Each channel is programmable as level or rising-edge, with write-1-to-clear status and a registered aggregate interrupt output. It sits on the same 12-bit address / 32-bit data register bus as the other ictc registers.

---
 rtl/ictc_irq_ctrl_regs.sv | 94 +++++++++
 tb/tb_ictc_irq_ctrl_regs.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ictc_irq_ctrl_regs.sv
// Interrupt enable/type/status/pending register bank for the ictc controller.
// Each channel is level or rising-edge; edge status is write-1-to-clear; irq is registered.
module ictc_irq_ctrl_regs #(
  parameter int          NUM_CH   = 8,
  parameter logic [11:0] IER_ADDR = 12'h14,
  parameter logic [11:0] ITR_ADDR = 12'h18,
  parameter logic [11:0] ISR_ADDR = 12'h1C,
  parameter logic [11:0] IPR_ADDR = 12'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       wr_data,
  input  logic [11:0]       addr,
  input  logic              wr_en,
  input  logic [NUM_CH-1:0] int_src,
  output logic [31:0]       rd_data,
  output logic              irq
);

  logic [NUM_CH-1:0] ier_reg, itr_reg, isr_reg;
  logic [NUM_CH-1:0] s1_reg, s2_reg, prev_reg;
  logic [NUM_CH-1:0] isr_next;
  logic [NUM_CH-1:0] ipr;
  logic [NUM_CH-1:0] wr_bits;
  logic              irq_reg;
  logic              ier_wr, itr_wr, isr_wr;

  assign ier_wr  = wr_en && (addr == IER_ADDR);
  assign itr_wr  = wr_en && (addr == ITR_ADDR);
  assign isr_wr  = wr_en && (addr == ISR_ADDR);
  assign wr_bits = wr_data[NUM_CH-1:0];
  assign ipr     = isr_reg & ier_reg;
  assign irq     = irq_reg;

  // Data bits above the channel count are intentionally dropped.
  generate
    if (NUM_CH < 32) begin : g_unused_hi
      logic unused_wr_hi;
      assign unused_wr_hi = |wr_data[31:NUM_CH];
    end
  endgenerate

  // Per-channel status update. A type change wipes the status bit first;
  // on edge channels a fresh rising edge beats a simultaneous W1C.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic type_chg;
      logic rise;
      assign type_chg = itr_wr && (wr_bits[gi] != itr_reg[gi]);
      assign rise     = s2_reg[gi] && !prev_reg[gi];
      assign isr_next[gi] = type_chg                    ? 1'b0 :
                            !itr_reg[gi]                ? s2_reg[gi] :
                            rise                        ? 1'b1 :
                            (isr_wr && wr_bits[gi])     ? 1'b0 :
                                                          isr_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier_reg  <= '0;
      itr_reg  <= '0;
      isr_reg  <= '0;
      s1_reg   <= '0;
      s2_reg   <= '0;
      prev_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      s1_reg   <= int_src;
      s2_reg   <= s1_reg;
      prev_reg <= s2_reg;
      isr_reg  <= isr_next;
      irq_reg  <= |ipr;
      if (ier_wr) ier_reg <= wr_bits;
      if (itr_wr) itr_reg <= wr_bits;
    end
  end

  // Reads are side-effect free and forced to zero while reset is held.
  always_comb begin
    rd_data = '0;
    if (rst_n) begin
      case (addr)
        IER_ADDR: rd_data[NUM_CH-1:0] = ier_reg;
        ITR_ADDR: rd_data[NUM_CH-1:0] = itr_reg;
        ISR_ADDR: rd_data[NUM_CH-1:0] = isr_reg;
        IPR_ADDR: rd_data[NUM_CH-1:0] = ipr;
        default:  rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ictc_irq_ctrl_regs.sv
// Bench for ictc_irq_ctrl_regs: per-cycle check against a history-based model,
// plus directed register/irq scenarios with literal expectations.
module tb_ictc_irq_ctrl_regs;

  localparam logic [11:0] IER = 12'h14;
  localparam logic [11:0] ITR = 12'h18;
  localparam logic [11:0] ISR = 12'h1C;
  localparam logic [11:0] IPR = 12'h20;
  localparam logic [11:0] UNM = 12'h40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wr_data = '0;
  logic [11:0] addr = '0;
  logic        wr_en = 1'b0;
  logic [7:0]  int_src = '0;
  logic [31:0] rd_data;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  ictc_irq_ctrl_regs #(.NUM_CH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .addr(addr),
    .wr_en(wr_en), .int_src(int_src), .rd_data(rd_data), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: a channel sees its source as it was two edges ago; an edge
  // channel latches when that view went 0->1 relative to one edge earlier.
  logic [7:0] m_ier, m_itr, m_isr;
  logic       m_irq;
  logic [7:0] hist [1:3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ier = '0; m_itr = '0; m_isr = '0; m_irq = 1'b0;
      for (int k = 1; k <= 3; k++) hist[k] = '0;
    end else begin
      logic [7:0] seen, seen_before, new_isr, wd;
      seen        = hist[2];
      seen_before = hist[3];
      wd          = wr_data[7:0];
      for (int i = 0; i < 8; i++) begin
        if (wr_en && addr == ITR && wd[i] != m_itr[i])      new_isr[i] = 1'b0;
        else if (!m_itr[i])                                  new_isr[i] = seen[i];
        else if (seen[i] && !seen_before[i])                 new_isr[i] = 1'b1;
        else if (wr_en && addr == ISR && wd[i])              new_isr[i] = 1'b0;
        else                                                 new_isr[i] = m_isr[i];
      end
      m_irq = (m_isr & m_ier) != 0;
      m_isr = new_isr;
      if (wr_en && addr == IER) m_ier = wd;
      if (wr_en && addr == ITR) m_itr = wd;
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = int_src;
    end
  end

  function automatic logic [31:0] model_rd(input logic [11:0] a);
    if (!rst_n) return 32'h0;
    case (a)
      IER:     return {24'h0, m_ier};
      ITR:     return {24'h0, m_itr};
      ISR:     return {24'h0, m_isr};
      IPR:     return {24'h0, m_isr & m_ier};
      default: return 32'h0;
    endcase
  endfunction

  // Per-cycle compare, sampled mid-period.
  always @(negedge clk) begin
    n_cmp++;
    if (irq !== m_irq) begin
      n_bad++;
      $display("FAIL cyc_irq t=%0t: got %b expected %b", $time, irq, m_irq);
    end
    n_cmp++;
    if (rd_data !== model_rd(addr)) begin
      n_bad++;
      $display("FAIL cyc_rd addr=%h t=%0t: got %h expected %h", addr, $time, rd_data, model_rd(addr));
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end else begin
      $display("ok   %s: %h", nm, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0; wr_data = '0; addr = ISR;
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, rd_data, exp);
  endtask

  initial begin
    // Reset state
    cyc(2);
    rd("rst_ier", IER, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    cyc(1);
    rd("rst_itr", ITR, 32'h0);
    rd("rst_isr", ISR, 32'h0);
    rd("rst_ipr", IPR, 32'h0);
    cyc(1);
    rd("rst_unmapped", UNM, 32'h0);
    rd("rst_ier2", IER, 32'h0);
    chk("rst_irq2", {31'h0, irq}, 32'h0);

    // Level channel 0; high bits of write data ignored
    cyc(1);
    wr(IER, 32'hFFFF_FF05);
    rd("ier_mask", IER, 32'h05);
    wr(IPR, 32'hFF);
    wr(UNM, 32'hFF);
    rd("ipr_write_ignored", IER, 32'h05);
    int_src[0] = 1'b1;
    cyc(2);                               // edges N, N+1
    cyc(1);                               // edge N+2
    rd("lvl_isr_n2", ISR, 32'h01);
    chk("lvl_irq_n2", {31'h0, irq}, 32'h0);
    cyc(1);                               // N+3
    chk("lvl_irq_n3", {31'h0, irq}, 32'h1);
    cyc(1);                               // N+4, then drop
    int_src[0] = 1'b0;
    cyc(3);
    chk("lvl_irq_drop3", {31'h0, irq}, 32'h1);
    cyc(1);
    chk("lvl_irq_drop4", {31'h0, irq}, 32'h0);

    // Edge channel 1 with W1C
    wr(ITR, 32'h02);
    wr(IER, 32'h02);
    int_src[1] = 1'b1;
    cyc(2);
    int_src[1] = 1'b0;
    cyc(5);
    rd("edge_isr_held", ISR, 32'h02);
    chk("edge_irq_held", {31'h0, irq}, 32'h1);
    wr(ISR, 32'h01);
    rd("w1c_wrong_bit", ISR, 32'h02);
    wr(ISR, 32'h02);
    rd("w1c_isr", ISR, 32'h00);
    chk("w1c_irq_same", {31'h0, irq}, 32'h1);
    cyc(1);
    chk("w1c_irq_next", {31'h0, irq}, 32'h0);

    // Set wins over simultaneous clear
    int_src[1] = 1'b1;
    cyc(2);
    int_src[1] = 1'b0;
    cyc(5);
    rd("pre_coll_isr", ISR, 32'h02);
    int_src[1] = 1'b1;
    cyc(2);                               // edges N, N+1
    addr = ISR; wr_data = 32'h02; wr_en = 1'b1;
    cyc(1);                               // edge N+2: set and clear collide
    wr_en = 1'b0; wr_data = '0;
    rd("coll_isr", ISR, 32'h02);
    chk("coll_irq", {31'h0, irq}, 32'h1);
    cyc(1);
    chk("coll_irq_next", {31'h0, irq}, 32'h1);
    int_src[1] = 1'b0;
    cyc(3);
    wr(ISR, 32'h02);
    cyc(1);

    // Channel 2 masked, then enabled, then type toggled
    wr(IER, 32'h00);
    int_src[2] = 1'b1;
    cyc(4);
    rd("mask_isr", ISR, 32'h04);
    rd("mask_ipr", IPR, 32'h00);
    chk("mask_irq", {31'h0, irq}, 32'h0);
    cyc(1);
    wr(IER, 32'h04);
    rd("en_ipr", IPR, 32'h04);
    chk("en_irq_same", {31'h0, irq}, 32'h0);
    cyc(1);
    chk("en_irq_next", {31'h0, irq}, 32'h1);
    wr(ITR, 32'h06);
    rd("tchg_isr", ISR, 32'h00);
    cyc(3);
    rd("tchg_isr_hold", ISR, 32'h00);
    chk("tchg_irq", {31'h0, irq}, 32'h0);

    // Async reset mid-cycle while irq is high
    wr(ITR, 32'h02);
    cyc(3);
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_irq", {31'h0, irq}, 32'h0);
    rd("async_isr", ISR, 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    rd("post_rst_isr", ISR, 32'h04);
    chk("post_rst_irq", {31'h0, irq}, 32'h0);
    wr(IER, 32'h04);
    cyc(1);
    chk("post_rst_irq_en", {31'h0, irq}, 32'h1);

    int_src = '0;
    cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
